// File: rtl/dcram_bist_bank.sv
// Banked RAM with a registered read port and an optional March C- self-test.
// The self-test is built only when DCRAM_BIST_EN is defined.
module dcram_bist_bank #(
  parameter int DW = 32,
  parameter int AW = 9,
  parameter int NB = 2
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic [NB*DW-1:0] data_in,
  input  logic [NB-1:0]    we,
  input  logic [AW-1:0]    addr,
  input  logic             enable,
  input  logic             bypass,
  input  logic             bist_start,
  input  logic             flt_inj,
  output logic [NB*DW-1:0] data_out,
  output logic             bist_busy,
  output logic             bist_done,
  output logic             bist_err_l,
  output logic [AW-1:0]    bist_fail_addr
);
  localparam int D = 1 << AW;

  logic [NB-1:0]    wr_en;
  logic [AW-1:0]    ram_addr;
  logic [NB*DW-1:0] wr_data;
  logic [NB*DW-1:0] rd_word;

`ifdef DCRAM_BIST_EN
  localparam logic [AW-1:0] FIRST = '0;
  localparam logic [AW-1:0] LAST  = '1;

  typedef enum logic [2:0] {
    IDLE, W0, R0W1_UP, R1W0_UP, R0W1_DN, R1W0_DN, R0_FIN, DONE
  } state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    cnt, cnt_nxt;
  logic             phase, phase_nxt;
  logic             bist_wr, wr_one, expect_one, cmp_en, descending, start_acc;
  logic             mismatch;
  logic [NB*DW-1:0] rdata_p1;
  logic [NB*DW-1:0] cmp_word;

  // phase 0 reads the word, phase 1 compares it and writes the inverse
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    phase_nxt  = phase;
    bist_wr    = 1'b0;
    wr_one     = 1'b0;
    expect_one = 1'b0;
    cmp_en     = 1'b0;
    descending = 1'b0;
    start_acc  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bist_start) begin
          start_acc = 1'b1;
          state_nxt = W0;
          cnt_nxt   = FIRST;
          phase_nxt = 1'b0;
        end
      end
      W0: begin
        bist_wr = 1'b1;
        if (cnt == LAST) begin
          state_nxt = R0W1_UP;
          cnt_nxt   = FIRST;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        expect_one = (state == R1W0_UP) || (state == R1W0_DN);
        wr_one     = !expect_one;
        descending = (state == R0W1_DN) || (state == R1W0_DN);
        phase_nxt  = !phase;
        if (phase) begin
          cmp_en  = 1'b1;
          bist_wr = (state != R0_FIN);
          if (cnt == (descending ? FIRST : LAST)) begin
            case (state)
              R0W1_UP: begin state_nxt = R1W0_UP; cnt_nxt = FIRST; end
              R1W0_UP: begin state_nxt = R0W1_DN; cnt_nxt = LAST;  end
              R0W1_DN: begin state_nxt = R1W0_DN; cnt_nxt = LAST;  end
              R1W0_DN: begin state_nxt = R0_FIN;  cnt_nxt = FIRST; end
              default: state_nxt = DONE;
            endcase
          end else begin
            cnt_nxt = descending ? cnt - 1'b1 : cnt + 1'b1;
          end
        end
      end
    endcase
  end

  assign bist_busy = (state != IDLE) && (state != DONE);
  assign bist_done = (state == DONE);

  assign wr_en    = bist_busy ? {NB{bist_wr}} : we;
  assign ram_addr = bist_busy ? cnt : addr;
  assign wr_data  = bist_busy ? {(NB*DW){wr_one}} : data_in;

  assign cmp_word = rdata_p1 ^ {{(NB*DW-1){1'b0}}, flt_inj};
  assign mismatch = cmp_en && (cmp_word != {(NB*DW){expect_one}});

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state          <= IDLE;
      cnt            <= '0;
      phase          <= 1'b0;
      bist_err_l     <= 1'b1;
      bist_fail_addr <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      phase <= phase_nxt;
      if (start_acc) begin
        bist_err_l     <= 1'b1;
        bist_fail_addr <= '0;
      end else if (mismatch) begin
        bist_err_l <= 1'b0;
        if (bist_err_l) bist_fail_addr <= cnt;
      end
    end
  end

  // read stage -> compare stage
  always_ff @(posedge clk) begin
    if (bist_busy && !phase) rdata_p1 <= rd_word;
  end
`else
  logic unused_bist_inputs;

  assign unused_bist_inputs = ^{bist_start, flt_inj};
  assign bist_busy      = 1'b0;
  assign bist_done      = 1'b0;
  assign bist_err_l     = 1'b1;
  assign bist_fail_addr = '0;
  assign wr_en          = we;
  assign ram_addr       = addr;
  assign wr_data        = data_in;
`endif

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [DW-1:0] mem [D];

    always_ff @(posedge clk) begin
      if (wr_en[b]) mem[ram_addr] <= wr_data[b*DW +: DW];
    end

    assign rd_word[b*DW +: DW] = mem[ram_addr];
  end

  // RAM read stage -> data_out; old data is returned on a same-address write
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      data_out <= '0;
    end else if (enable && !bist_busy) begin
      data_out <= bypass ? data_in : rd_word;
    end
  end

endmodule

// File: tb/tb_dcram_bist_bank.sv
// Randomized bench for dcram_bist_bank (AW=4, DW=8, NB=2) with a cycle-level
// behavioural model; BIST scenarios depend on DCRAM_BIST_EN.
module tb_dcram_bist_bank;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NB = 2;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          reset_l = 1'b1;
  logic [15:0]   data_in = '0;
  logic [1:0]    we = '0;
  logic [3:0]    addr = '0;
  logic          enable = 1'b0;
  logic          bypass = 1'b0;
  logic          bist_start = 1'b0;
  logic          flt_inj = 1'b0;
  logic [15:0]   data_out;
  logic          bist_busy;
  logic          bist_done;
  logic          bist_err_l;
  logic [3:0]    bist_fail_addr;

  int checks = 0;
  int failures = 0;
  logic check_en = 1'b0;

  dcram_bist_bank #(.DW(DW), .AW(AW), .NB(NB)) dut (
    .clk(clk), .reset_l(reset_l), .data_in(data_in), .we(we), .addr(addr),
    .enable(enable), .bypass(bypass), .bist_start(bist_start), .flt_inj(flt_inj),
    .data_out(data_out), .bist_busy(bist_busy), .bist_done(bist_done),
    .bist_err_l(bist_err_l), .bist_fail_addr(bist_fail_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference March C- run: find the first compare that sees a wrong word.
  // Compare number n happens in busy cycle D + 2n + 2.
  function automatic void march_sim(input logic flt, output int err_cyc, output logic [3:0] faddr);
    logic [15:0] mm [16];
    logic [15:0] rd;
    logic [15:0] bg;
    int a;
    int n;
    err_cyc = 0;
    faddr = '0;
    n = 0;
    for (int i = 0; i < D; i++) mm[i] = '0;
    for (int e = 0; e < 5; e++) begin
      for (int k = 0; k < D; k++) begin
        a  = (e == 2 || e == 3) ? D - 1 - k : k;
        bg = (e == 1 || e == 3) ? 16'hFFFF : 16'h0000;
        rd = mm[a] ^ {15'd0, flt};
        if (rd != bg && err_cyc == 0) begin
          err_cyc = D + 2 * n + 2;
          faddr = a[3:0];
        end
        if (e < 4) mm[a] = ~bg;
        n++;
      end
    end
  endfunction

  logic [15:0] exp_dout = '0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic        exp_err_l = 1'b1;
  logic [3:0]  exp_fail = '0;
  int          m_cyc = 0;
  int          m_err_cyc = 0;
  logic [3:0]  m_faddr = '0;
  logic [7:0]  m_mem [2][16];

  always begin
    @(posedge clk or negedge reset_l);
    if (!reset_l) begin
      exp_dout = '0; exp_busy = 1'b0; exp_done = 1'b0;
      exp_err_l = 1'b1; exp_fail = '0; m_cyc = 0;
    end else if (exp_busy) begin
      if (m_cyc == m_err_cyc) begin
        exp_err_l = 1'b0;
        exp_fail = m_faddr;
      end
      if (m_cyc == 11 * D) begin
        exp_busy = 1'b0;
        exp_done = 1'b1;
      end
      m_cyc++;
    end else begin
      if (enable) exp_dout = bypass ? data_in : {m_mem[1][addr], m_mem[0][addr]};
      for (int b = 0; b < NB; b++)
        if (we[b]) m_mem[b][addr] = data_in[b*8 +: 8];
`ifdef DCRAM_BIST_EN
      if (bist_start) begin
        exp_busy = 1'b1; exp_done = 1'b0; exp_err_l = 1'b1; exp_fail = '0;
        m_cyc = 1;
        march_sim(flt_inj, m_err_cyc, m_faddr);
        for (int b = 0; b < NB; b++)
          for (int i = 0; i < D; i++) m_mem[b][i] = '0;
      end
`endif
    end
  end

  always begin
    @(negedge clk);
    if (check_en) begin
      chk("data_out", 32'(data_out), 32'(exp_dout));
      chk("bist_busy", 32'(bist_busy), 32'(exp_busy));
      chk("bist_done", 32'(bist_done), 32'(exp_done));
      chk("bist_err_l", 32'(bist_err_l), 32'(exp_err_l));
      chk("bist_fail_addr", 32'(bist_fail_addr), 32'(exp_fail));
    end
  end

  task automatic rand_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      we = 2'($urandom); addr = 4'($urandom); data_in = 16'($urandom);
      enable = 1'($urandom); bypass = ($urandom_range(0, 3) == 0);
      flt_inj = 1'($urandom);
`ifdef DCRAM_BIST_EN
      bist_start = 1'b0;
`else
      bist_start = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end
    we = '0; enable = 1'b0; bypass = 1'b0; bist_start = 1'b0; flt_inj = 1'b0;
  endtask

  task automatic run_bist(input logic flt, output int ncyc);
    flt_inj = flt;
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    ncyc = 0;
    while (bist_busy === 1'b1 && ncyc < 400) begin
      ncyc++;
      we = 2'($urandom); addr = 4'($urandom); data_in = 16'($urandom);
      enable = 1'($urandom); bypass = 1'($urandom);
      bist_start = ($urandom_range(0, 15) == 0);
      tick();
    end
    bist_start = 1'b0; we = '0; enable = 1'b0; bypass = 1'b0;
  endtask

  initial begin
    int n;
    #1 reset_l = 1'b0;
    repeat (3) tick();
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_busy", 32'(bist_busy), 32'h0);
    chk("rst_done", 32'(bist_done), 32'h0);
    chk("rst_err_l", 32'(bist_err_l), 32'h1);
    chk("rst_fail_addr", 32'(bist_fail_addr), 32'h0);
    reset_l = 1'b1;
    check_en = 1'b1;
    tick();

    for (int a = 0; a < D; a++) begin
      we = 2'b11; addr = 4'(a); data_in = 16'($urandom);
      tick();
    end
    we = 2'b00;

    we = 2'b10; addr = 4'd3; data_in = 16'hA55A;
    tick();
    we = 2'b00; enable = 1'b1;
    tick();
    chk("read_a5", 32'(data_out[15:8]), 32'hA5);

    bypass = 1'b1; data_in = 16'h1234;
    tick();
    chk("bypass_1234", 32'(data_out), 32'h1234);
    bypass = 1'b0; data_in = '0;
    tick();
    chk("ram_after_bypass", 32'(data_out[15:8]), 32'hA5);
    enable = 1'b0;

    rand_traffic(300);

`ifdef DCRAM_BIST_EN
    run_bist(1'b0, n);
    chk("bist_cycles", n, 176);
    chk("bist_done_pass", 32'(bist_done), 32'h1);
    chk("bist_err_pass", 32'(bist_err_l), 32'h1);
    flt_inj = 1'b0;
    enable = 1'b1; addr = 4'd3;
    tick();
    chk("ram_zero_after_bist", 32'(data_out), 32'h0);
    enable = 1'b0;

    run_bist(1'b1, n);
    chk("flt_cycles", n, 176);
    chk("flt_err_l", 32'(bist_err_l), 32'h0);
    chk("flt_fail_addr", 32'(bist_fail_addr), 32'h0);
    chk("flt_done", 32'(bist_done), 32'h1);
    flt_inj = 1'b0;

    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    repeat (49) tick();
    chk("busy_at_50", 32'(bist_busy), 32'h1);
    reset_l = 1'b0;
    #2;
    chk("abort_busy", 32'(bist_busy), 32'h0);
    chk("abort_done", 32'(bist_done), 32'h0);
    chk("abort_err_l", 32'(bist_err_l), 32'h1);
    chk("abort_fail_addr", 32'(bist_fail_addr), 32'h0);
    chk("abort_data_out", 32'(data_out), 32'h0);
    repeat (2) tick();
    reset_l = 1'b1;
    tick();
    run_bist(1'b0, n);
    chk("rerun_cycles", n, 176);
    chk("rerun_err_l", 32'(bist_err_l), 32'h1);
    chk("rerun_done", 32'(bist_done), 32'h1);
`else
    for (int i = 0; i < 4; i++) begin
      bist_start = 1'b1; flt_inj = 1'b1;
      tick();
      bist_start = 1'b0;
      tick();
      chk("nobist_busy", 32'(bist_busy), 32'h0);
      chk("nobist_err_l", 32'(bist_err_l), 32'h1);
      chk("nobist_done", 32'(bist_done), 32'h0);
    end
    flt_inj = 1'b0;
    we = 2'b01; addr = 4'd5; data_in = 16'h003C;
    tick();
    we = 2'b00; enable = 1'b1;
    tick();
    chk("nobist_read", 32'(data_out[7:0]), 32'h3C);
    enable = 1'b0;
`endif

    rand_traffic(300);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
